// File: rtl/regfile_pkg.sv
// Shared defaults and type aliases for the parametrised register file.
// reg_addr_t / reg_word_t match the classic 32x32 layout that the older
// VECTOR_ADDR / VECTOR_RANGE macros described.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_MAX_PEND = 3;
    localparam int DEF_AW       = $clog2(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]     reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register.
// Counts writes issued from ID that have not yet reached writeback.
// Reports per-read-port RAW hazards and whether the issue target has room.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int MAX_PEND = DEF_MAX_PEND,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_RD*AW-1:0] rs_addr_i,
    output logic [NUM_RD-1:0]    rs_busy_o,
    input  logic                 regs_wr_en_i,
    input  logic [AW-1:0]        rd_addr_i,
    input  logic                 issue_vld_i,
    input  logic [AW-1:0]        issue_rd_addr_i,
    output logic                 issue_rdy_o
);

    localparam int             CW       = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0]  PEND_MAX = CW'(MAX_PEND);
    localparam logic [CW-1:0]  PEND_ONE = CW'(1);

    logic [CW-1:0] pend     [DEPTH];
    logic [CW-1:0] pend_nxt [DEPTH];
    logic          issue_ok;

    assign issue_rdy_o = (pend[issue_rd_addr_i] != PEND_MAX);
    assign issue_ok    = issue_vld_i && issue_rdy_o;

    // Next count per register: issue and writeback on the same register cancel.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            logic inc, dec;
            inc = issue_ok && (issue_rd_addr_i == AW'(r)) && !(ZERO_REG != 0 && r == 0);
            dec = regs_wr_en_i && (rd_addr_i == AW'(r));
            pend_nxt[r] = pend[r];
            if (inc && !dec)
                pend_nxt[r] = pend[r] + PEND_ONE;
            else if (dec && !inc && pend[r] != '0)
                pend_nxt[r] = pend[r] - PEND_ONE;
        end
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < DEPTH; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) pend[r] <= pend_nxt[r];
        end
    end

    // Busy unless x0, or the last pending write is being bypassed right now.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [AW-1:0] addr;
        logic [CW-1:0] cnt;
        assign addr = rs_addr_i[k*AW +: AW];
        assign cnt  = pend[addr];
        assign rs_busy_o[k] = (cnt != '0)
                           && !(ZERO_REG != 0 && addr == '0)
                           && !(cnt == PEND_ONE && regs_wr_en_i && rd_addr_i == addr);
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with WB->ID bypass and a pending-write
// scoreboard. Storage and read muxes live here; hazard tracking is delegated.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int MAX_PEND = DEF_MAX_PEND,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*AW-1:0]     rs_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rs_data_o,
    output logic [NUM_RD-1:0]        rs_busy_o,
    input  logic                     regs_wr_en_i,
    input  logic [AW-1:0]            rd_addr_i,
    input  logic [DATA_W-1:0]        rd_data_i,
    input  logic                     issue_vld_i,
    input  logic [AW-1:0]            issue_rd_addr_i,
    output logic                     issue_rdy_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = regs_wr_en_i && !(ZERO_REG != 0 && rd_addr_i == '0);

    // Storage: async clear, writes to x0 dropped when it is hard-wired.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else if (wr_ok) begin
            mem[rd_addr_i] <= rd_data_i;
        end
    end

    // Combinational read ports, each with its own writeback bypass.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rs_addr_i[k*AW +: AW];
        always_comb begin
            rs_data_o[k*DATA_W +: DATA_W] = mem[addr];
            if (ZERO_REG != 0 && addr == '0)
                rs_data_o[k*DATA_W +: DATA_W] = '0;
            else if (regs_wr_en_i && rd_addr_i == addr)
                rs_data_o[k*DATA_W +: DATA_W] = rd_data_i;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .MAX_PEND (MAX_PEND),
        .AW       (AW)
    ) u_sb (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rs_addr_i       (rs_addr_i),
        .rs_busy_o       (rs_busy_o),
        .regs_wr_en_i    (regs_wr_en_i),
        .rd_addr_i       (rd_addr_i),
        .issue_vld_i     (issue_vld_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .issue_rdy_o     (issue_rdy_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (defaults: 32x32, 2 read ports, x0 wired, MAX_PEND=3).
// An array model of registers and pending counts predicts every output each cycle;
// literal expectations at key points pin the model itself.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        issue_vld;
    logic [4:0]  issue_addr;
    logic        issue_rdy;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .rs_addr_i       (rs_addr),
        .rs_data_o       (rs_data),
        .rs_busy_o       (rs_busy),
        .regs_wr_en_i    (wr_en),
        .rd_addr_i       (rd_addr),
        .rd_data_i       (rd_data),
        .issue_vld_i     (issue_vld),
        .issue_rd_addr_i (issue_addr),
        .issue_rdy_o     (issue_rdy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem  [32];
    int          m_pend [32];

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en && rd_addr == a) return rd_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (m_pend[a] == 0) return 1'b0;
        if (m_pend[a] == 1 && wr_en && rd_addr == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_rdy();
        return m_pend[issue_addr] != 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = 32'd0;
                m_pend[r] = 0;
            end
        end else begin
            bit inc_ok;
            inc_ok = issue_vld && issue_addr != 5'd0 && m_pend[issue_addr] != 3;
            if (wr_en && rd_addr != 5'd0) m_mem[rd_addr] = rd_data;
            if (inc_ok && wr_en && rd_addr == issue_addr) begin
                // issue and retire of the same register cancel out
            end else begin
                if (wr_en && m_pend[rd_addr] > 0) m_pend[rd_addr] = m_pend[rd_addr] - 1;
                if (inc_ok) m_pend[issue_addr] = m_pend[issue_addr] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model rs_data0", {32'd0, rs_data[31:0]},  {32'd0, exp_data(rs_addr[4:0])});
        chk("model rs_data1", {32'd0, rs_data[63:32]}, {32'd0, exp_data(rs_addr[9:5])});
        chk("model rs_busy0", {63'd0, rs_busy[0]}, {63'd0, exp_busy(rs_addr[4:0])});
        chk("model rs_busy1", {63'd0, rs_busy[1]}, {63'd0, exp_busy(rs_addr[9:5])});
        chk("model issue_rdy", {63'd0, issue_rdy}, {63'd0, exp_rdy()});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_vld = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; rd_addr = a; rd_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        issue_vld = 1'b1; issue_addr = a;
    endtask

    initial begin
        rst_n = 1'b1; idle(); rd_addr = '0; rd_data = '0; issue_addr = '0;
        rd(5'd2, 5'd5);
        #3 rst_n = 1'b0;
        #1;
        chk("reset data0", {32'd0, rs_data[31:0]}, 64'd0);
        chk("reset data1", {32'd0, rs_data[63:32]}, 64'd0);
        chk("reset busy", {62'd0, rs_busy}, 64'd0);
        chk("reset rdy", {63'd0, issue_rdy}, 64'd1);
        step(); step();
        #2 rst_n = 1'b1;

        // write then read
        step(); wb(5'd2, 32'hABCD_ABCD);
        step(); wb(5'd5, 32'hAAAA_AAAA);
        step(); idle(); rd(5'd2, 5'd5);
        #1;
        chk("rd x2", {32'd0, rs_data[31:0]}, 64'h0000_0000_ABCD_ABCD);
        chk("rd x5", {32'd0, rs_data[63:32]}, 64'h0000_0000_AAAA_AAAA);

        // same-cycle bypass on both ports
        step(); wb(5'd7, 32'h1234_5678); rd(5'd7, 5'd7);
        #1;
        chk("bypass p0", {32'd0, rs_data[31:0]}, 64'h0000_0000_1234_5678);
        chk("bypass p1", {32'd0, rs_data[63:32]}, 64'h0000_0000_1234_5678);
        step(); idle();
        #1;
        chk("x7 stored", {32'd0, rs_data[31:0]}, 64'h0000_0000_1234_5678);

        // x0 hard-wired and never counted
        step(); wb(5'd0, 32'hFFFF_FFFF); rd(5'd0, 5'd0);
        #1;
        chk("x0 bypass blocked", {32'd0, rs_data[31:0]}, 64'd0);
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            iss(5'd0);
            step();
        end
        #1;
        chk("x0 read", {32'd0, rs_data[31:0]}, 64'd0);
        chk("x0 busy", {62'd0, rs_busy}, 64'd0);
        chk("x0 rdy", {63'd0, issue_rdy}, 64'd1);

        // scoreboard on x3: two issues, then issue+retire same cycle (stays 2)
        idle(); rd(5'd3, 5'd3);
        iss(5'd3); step(); step();
        wb(5'd3, 32'h0000_0033);
        #1;
        chk("x3 busy@2", {63'd0, rs_busy[0]}, 64'd1);
        step(); idle(); iss(5'd3);
        #1;
        chk("x3 rdy@2", {63'd0, issue_rdy}, 64'd1);
        step();
        #1;
        chk("x3 rdy@3", {63'd0, issue_rdy}, 64'd0);
        step();   // 4th issue, ignored
        idle();
        #1;
        // three writebacks from a count of 3
        wb(5'd3, 32'h0000_0301); step();
        wb(5'd3, 32'h0000_0302);
        #1;
        chk("x3 busy@2 in wb", {63'd0, rs_busy[0]}, 64'd1);
        step(); wb(5'd3, 32'h0000_0303);
        #1;
        chk("x3 busy last wb", {62'd0, rs_busy}, 64'd0);
        chk("x3 last bypass", {32'd0, rs_data[31:0]}, 64'h0000_0000_0000_0303);
        step(); idle();
        #1;
        chk("x3 busy after", {62'd0, rs_busy}, 64'd0);

        // untracked write saturates at 0, then one issue -> count 1, not wrapped
        wb(5'd6, 32'h0000_0066); rd(5'd6, 5'd6);
        step(); idle(); iss(5'd6);
        step(); idle(); issue_addr = 5'd6;
        #1;
        chk("x6 busy@1", {62'd0, rs_busy}, 64'd3);
        chk("x6 rdy@1", {63'd0, issue_rdy}, 64'd1);
        wb(5'd6, 32'h0000_0067); step(); idle();

        // async reset mid-operation: pend[x3]=2 with x4 written on other reg same cycle
        iss(5'd3); wb(5'd4, 32'h0000_0055); step();
        idle(); iss(5'd3); step();
        idle(); rd(5'd3, 5'd4);
        #1;
        chk("pre-rst busy x3", {63'd0, rs_busy[0]}, 64'd1);
        chk("pre-rst x4", {32'd0, rs_data[63:32]}, 64'h0000_0000_0000_0055);
        rst_n = 1'b0;
        #1;
        chk("mid-rst busy", {62'd0, rs_busy}, 64'd0);
        chk("mid-rst x4", {32'd0, rs_data[63:32]}, 64'd0);
        chk("mid-rst rdy", {63'd0, issue_rdy}, 64'd1);
        step();
        #2 rst_n = 1'b1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
